mux_scan_nx1: RTL and testbench
===============================

Name: mux_scan_nx1

Overview:
- Parametrised N-channel, W-bit-wide registered multiplexer; the next generation of the combinational 8x1 mux.
- Two modes:
  - Direct select: a one-cycle registered equivalent of the 8x1 mux.
  - Auto-scan: an internal pointer steps through all channels, with a programmable dwell time per channel.
- Used wherever a shared sink samples several sources, e.g. a status/debug readout or a time-multiplexed monitor.

Parameters:
- N, 8, number of input channels (2..64).
- W, 1, width of each channel in bits.
- DWELL, 1, cycles spent on each channel in scan mode (1..256).
- SW, $clog2(N), select/pointer width; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_bus  input  N*W  packed channel inputs; channel k occupies in_bus[k*W +: W].
- sel  input  SW  channel select in direct mode; start channel on entry to scan.
- mode  input  1  0 = direct, 1 = scan.
- en  input  1  enables operation; when 0, the block holds its state.
- y  output  W  registered selected channel data.
- y_valid  output  1  y holds valid data sampled in the previous cycle.
- ch  output  SW  channel index that y was sampled from.
- wrap  output  1  one-cycle pulse, aligned with y, when scan wraps from N-1 to 0.
- sel_err  output  1  registered flag: direct-mode sel >= N (only possible when N is not a power of 2).

Behaviour:
- Reset (rst=1 at a clock edge): y=0, y_valid=0, ch=0, wrap=0, sel_err=0, ptr=0, dwell_cnt=0, state=IDLE. Reset overrides every other input, including mid-scan.
- Latency: exactly 1 cycle, in_bus/sel to y/ch, in all modes. There is no combinational path from in_bus to y.
- FSM states and transitions:
  - IDLE: y_valid=0 and y holds its value. On en=1, go to DIRECT if mode=0, or SCAN if mode=1.
  - DIRECT:
    - Each cycle with en=1 and sel < N: y<=in_bus[sel], ch<=sel, y_valid<=1, sel_err<=0.
    - sel >= N: y<=0, ch unchanged, y_valid<=0, sel_err<=1.
    - mode=1 with en=1: go to SCAN and load ptr<=sel (sel >= N loads 0) and dwell_cnt<=0. The entry cycle already outputs channel ptr.
  - SCAN:
    - Each cycle with en=1: y<=in_bus[ptr], ch<=ptr, y_valid<=1, sel_err<=0.
    - dwell_cnt increments. When dwell_cnt==DWELL-1, it clears and ptr advances: ptr<=(ptr==N-1)?0:ptr+1.
    - wrap<=1 in the cycle y first shows channel 0 after channel N-1. It is 0 at every other time, including scan entry at sel=0.
    - mode=0 with en=1: go to DIRECT; that cycle uses direct behaviour. ptr and dwell_cnt are retained but unused.
  - Any state with en=0: go to IDLE. y, ch, ptr and dwell_cnt are frozen; y_valid<=0 and wrap<=0. Re-enabling in scan resumes from the frozen ptr/dwell_cnt; ptr is not reloaded from sel.
    - To make this decidable, IDLE remembers whether it was entered from SCAN via a resume bit.
    - The resume bit clears on reset or on any cycle spent in DIRECT.
- Pointer arithmetic is modulo N, and non-power-of-2 N must wrap at N-1. dwell_cnt is $clog2(DWELL+1) bits wide. DWELL=1 means ptr advances every cycle.
- Simultaneous events:
  - A mode toggle and a dwell expiry in the same cycle: the mode toggle wins, and ptr does not advance.
  - When en falls, the in-flight sample still issues at that edge? No. Samples are taken only on edges where en=1.

Decomposition:
- Package mux_pkg: state enum (IDLE, DIRECT, SCAN) and a clog2-safe width helper constant for SW when N=1 is rejected.
- One natural sub-module, scan_ptr: ptr and dwell counter with load, advance and wrap outputs. The mux datapath and FSM live in the top module.

Test Plan (N=8, W=4, DWELL=2 unless stated):
1. Reset: assert rst for 2 cycles mid-scan -> next cycle y=0, y_valid=0, ch=0, wrap=0. After release with en=0, the block stays IDLE.
2. Direct: in_bus=32'h76543210, mode=0, en=1, sel=5 -> one cycle later y=4'h5, ch=5, y_valid=1. Changing sel to 2 updates y to 2 exactly one cycle later.
3. Scan: mode=1, sel=6, en=1 -> y sequence 6,6,7,7,0,0,1,... with wrap=1 only on the first cycle showing 0.
4. Freeze/resume: in scan, drop en for 3 cycles while on channel 3 after its first dwell cycle -> y_valid=0 and y holds 3. Raising en then gives one more cycle of channel 3, then 4.
5. Non-power-of-2: N=5, DWELL=1, direct sel=6 -> y=0, y_valid=0, sel_err=1. In scan, the sequence is 0,1,2,3,4,0 with wrap on the second 0.
6. Mode switch mid-dwell: scan on channel 2, first dwell cycle, with sel=7; assert mode=0 -> next cycle y=in[7], ch=7, wrap=0.

Source files
------------

// File: rtl/mux_scan_nx1_pkg.sv
// Shared definitions for the scanning N-to-1 registered multiplexer.
//   state_t    : control FSM states (IDLE, DIRECT, SCAN)
//   clog2_safe : index width helper that never returns 0, so a
//                degenerate single-channel build still gets a 1-bit select
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  function automatic int clog2_safe(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_nx1_scan_ptr.sv
// Scan pointer and dwell counter for mux_scan_nx1.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   step      : a scan sample is taken at this edge, so count it
//   load      : this sample starts a fresh scan at load_val
//   load_val  : start channel (already range-checked by the caller)
//   cur_ptr   : channel the sample at this edge is taken from
//   wrap_now  : the sample at this edge is the first view of channel 0
//               after channel N-1
module scan_ptr
  import mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int DWELL = 1,
  parameter int SW    = clog2_safe(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          load,
  input  logic [SW-1:0] load_val,
  output logic [SW-1:0] cur_ptr,
  output logic          wrap_now
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [SW-1:0] LAST_CH  = SW'(N - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [SW-1:0] ptr_q;
  logic [CW-1:0] cnt_q;
  logic          wrapped_q;
  logic [CW-1:0] base_cnt;
  logic          expire;
  logic          at_last;

  // A load makes the entry sample count as the first dwell cycle of the
  // loaded channel, so the entry edge is treated as dwell_cnt = 0 there.
  // wrapped_q remembers that the pointer reached 0 by wrapping; together
  // with dwell_cnt = 0 it marks the very first sample of channel 0, which
  // also survives a freeze that happens right at the wrap point.
  always_comb begin
    cur_ptr  = load ? load_val : ptr_q;
    base_cnt = load ? '0 : cnt_q;
    expire   = (base_cnt == CNT_LAST);
    at_last  = (cur_ptr == LAST_CH);
    wrap_now = !load && wrapped_q && (ptr_q == '0) && (cnt_q == '0);
  end

  // Pointer and counter only move on edges where a scan sample is taken;
  // everything else (direct mode, disabled) leaves them frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      cnt_q     <= '0;
      wrapped_q <= 1'b0;
    end else if (step) begin
      if (expire) begin
        cnt_q     <= '0;
        ptr_q     <= at_last ? '0 : cur_ptr + SW'(1);
        wrapped_q <= at_last;
      end else begin
        cnt_q     <= base_cnt + CW'(1);
        ptr_q     <= cur_ptr;
        wrapped_q <= load ? 1'b0 : wrapped_q;
      end
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N-channel, W-bit multiplexer with direct-select and
// auto-scan modes.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   in_bus   : N packed channels, channel k at in_bus[k*W +: W]
//   sel      : direct-mode channel, or scan start channel
//   mode     : 0 = direct select, 1 = auto-scan
//   en       : 0 freezes the block (IDLE), 1 runs it
//   y        : registered channel data
//   y_valid  : y was sampled at the previous edge
//   ch       : channel index y was taken from
//   wrap     : pulse with the first channel-0 sample after channel N-1
//   sel_err  : direct-mode sel was out of range (sel >= N)
module mux_scan_nx1
  import mux_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int W     = 1,
  parameter  int DWELL = 1,
  localparam int SW    = clog2_safe(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_bus,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           en,
  output logic [W-1:0]   y,
  output logic           y_valid,
  output logic [SW-1:0]  ch,
  output logic           wrap,
  output logic           sel_err
);

  localparam logic [SW:0] N_EXT = (SW + 1)'(N);

  state_t        state_q, state_d;
  logic          resume_q, resume_d;
  logic [W-1:0]  y_d;
  logic          y_valid_d;
  logic [SW-1:0] ch_d;
  logic          wrap_d;
  logic          sel_err_d;

  logic          sel_ok;
  logic [SW-1:0] sel_safe;
  logic          scan_step;
  logic          scan_load;
  logic [SW-1:0] scan_ch;
  logic          scan_wrap;
  logic [SW-1:0] mux_idx;
  logic [W-1:0]  mux_data;

  // The extra top bit keeps the range check meaningful when N is a power
  // of two. Out-of-range selects are steered to channel 0 so the mux index
  // never leaves the bus.
  assign sel_ok   = ({1'b0, sel} < N_EXT);
  assign sel_safe = sel_ok ? sel : '0;
  assign mux_idx  = mode ? scan_ch : sel_safe;
  assign mux_data = in_bus[int'(mux_idx) * W +: W];

  scan_ptr #(
    .N     (N),
    .DWELL (DWELL),
    .SW    (SW)
  ) u_scan_ptr (
    .clk      (clk),
    .rst      (rst),
    .step     (scan_step),
    .load     (scan_load),
    .load_val (sel_safe),
    .cur_ptr  (scan_ch),
    .wrap_now (scan_wrap)
  );

  // Every enabled edge samples, whatever state we come from, which gives
  // the one-cycle latency from IDLE as well. A scan reloads from sel only
  // when it is a fresh start: out of DIRECT, or out of an IDLE that was
  // not entered from SCAN. resume_q carries that history through IDLE.
  always_comb begin
    state_d   = state_q;
    resume_d  = resume_q;
    y_d       = y;
    y_valid_d = 1'b0;
    ch_d      = ch;
    wrap_d    = 1'b0;
    sel_err_d = sel_err;
    scan_step = 1'b0;
    scan_load = 1'b0;

    if (!en) begin
      state_d = IDLE;
    end else if (mode) begin
      state_d   = SCAN;
      resume_d  = 1'b1;
      scan_step = 1'b1;
      scan_load = (state_q == DIRECT) || ((state_q == IDLE) && !resume_q);
      y_d       = mux_data;
      ch_d      = scan_ch;
      y_valid_d = 1'b1;
      wrap_d    = scan_wrap;
      sel_err_d = 1'b0;
    end else begin
      state_d  = DIRECT;
      resume_d = 1'b0;
      if (sel_ok) begin
        y_d       = mux_data;
        ch_d      = sel;
        y_valid_d = 1'b1;
        sel_err_d = 1'b0;
      end else begin
        y_d       = '0;
        sel_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      resume_q <= 1'b0;
      y        <= '0;
      y_valid  <= 1'b0;
      ch       <= '0;
      wrap     <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      y        <= y_d;
      y_valid  <= y_valid_d;
      ch       <= ch_d;
      wrap     <= wrap_d;
      sel_err  <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Self-checking bench for mux_scan_nx1: an 8-channel, 4-bit, dwell-2
// instance plus a 5-channel, dwell-1 instance for the non-power-of-two
// cases. Expected outputs are queued when inputs are driven and popped
// one edge later. Outputs are packed as {y, y_valid, ch, wrap, sel_err}.
module tb_mux_scan_nx1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] in8;
  logic [2:0]  sel8;
  logic        mode8, en8;
  logic [3:0]  y8;
  logic        v8, wr8, err8;
  logic [2:0]  ch8;

  logic [19:0] in5;
  logic [2:0]  sel5;
  logic        mode5, en5;
  logic [3:0]  y5;
  logic        v5, wr5, err5;
  logic [2:0]  ch5;

  logic [9:0] sb[$];
  int errors = 0;
  int checks = 0;

  mux_scan_nx1 #(.N(8), .W(4), .DWELL(2)) dut (
    .clk(clk), .rst(rst), .in_bus(in8), .sel(sel8), .mode(mode8), .en(en8),
    .y(y8), .y_valid(v8), .ch(ch8), .wrap(wr8), .sel_err(err8)
  );

  mux_scan_nx1 #(.N(5), .W(4), .DWELL(1)) dut5 (
    .clk(clk), .rst(rst), .in_bus(in5), .sel(sel5), .mode(mode5), .en(en5),
    .y(y5), .y_valid(v5), .ch(ch5), .wrap(wr5), .sel_err(err5)
  );

  function automatic logic [9:0] pk(input logic [3:0] yv, input logic v,
                                    input logic [2:0] c, input logic w,
                                    input logic e);
    return {yv, v, c, w, e};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en8 = 1'b0; en5 = 1'b0; mode8 = 1'b0; mode5 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] stim [8];
    logic [9:0] expv [8];
    logic [9:0] got, exp;
    stim = '{6'b011_011, 6'b011_011, 6'b011_011, 6'b111_011,
             6'b111_011, 6'b000_011, 6'b000_011, 6'b011_101};
    expv = '{pk(3,1,3,0,0), pk(3,1,3,0,0), pk(4,1,4,0,0), pk(0,0,0,0,0),
             pk(0,0,0,0,0), pk(0,0,0,0,0), pk(0,0,0,0,0), pk(5,1,5,0,0)};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {rst, en8, mode8, sel8} = stim[i];
      sb.push_back(expv[i]);
      @(posedge clk); #1;
      got = {y8, v8, ch8, wr8, err8};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL reset[%0d]: got {y,v,ch,wrap,err}=%b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_direct();
    logic [5:0] stim [5];
    logic [9:0] expv [5];
    logic [9:0] got, exp;
    logic [2:0] s;
    stim = '{6'b010_101, 6'b010_010, 6'b010_111, 6'b000_001, 6'b010_000};
    expv = '{pk(5,1,5,0,0), pk(2,1,2,0,0), pk(7,1,7,0,0), pk(7,0,7,0,0),
             pk(0,1,0,0,0)};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      {rst, en8, mode8, sel8} = stim[i];
      sb.push_back(expv[i]);
      @(posedge clk); #1;
      got = {y8, v8, ch8, wr8, err8};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL direct[%0d]: got {y,v,ch,wrap,err}=%b required %b", i, got, exp);
      end
    end
    for (int i = 0; i < 6; i++) begin
      s = 3'($urandom_range(0, 7));
      @(negedge clk);
      in8 = $urandom;
      rst = 1'b0; en8 = 1'b1; mode8 = 1'b0; sel8 = s;
      sb.push_back(pk(in8[int'(s) * 4 +: 4], 1'b1, s, 1'b0, 1'b0));
      @(posedge clk); #1;
      got = {y8, v8, ch8, wr8, err8};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL direct_data[%0d]: got {y,v,ch,wrap,err}=%b required %b", i, got, exp);
      end
    end
    @(negedge clk);
    in8 = 32'h7654_3210;
  endtask

  task automatic test_scan();
    logic [3:0] ys [8];
    logic [9:0] got, exp;
    ys = '{4'd6, 4'd6, 4'd7, 4'd7, 4'd0, 4'd0, 4'd1, 4'd1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = 1'b0; en8 = 1'b1; mode8 = 1'b1;
      sel8 = (i == 0) ? 3'd6 : 3'd2;
      sb.push_back(pk(ys[i], 1'b1, ys[i][2:0], (i == 4), 1'b0));
      @(posedge clk); #1;
      got = {y8, v8, ch8, wr8, err8};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL scan[%0d]: got {y,v,ch,wrap,err}=%b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_scan_full();
    logic [9:0] got, exp;
    int c;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      c = (i / 2) % 8;
      @(negedge clk);
      rst = 1'b0; en8 = 1'b1; mode8 = 1'b1; sel8 = 3'd0;
      sb.push_back(pk(4'(c), 1'b1, 3'(c), (i == 16), 1'b0));
      @(posedge clk); #1;
      got = {y8, v8, ch8, wr8, err8};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL scan_full[%0d]: got {y,v,ch,wrap,err}=%b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_freeze();
    logic [5:0] stim [10];
    logic [9:0] expv [10];
    logic [9:0] got, exp;
    stim = '{6'b011_010, 6'b011_010, 6'b011_010, 6'b001_010, 6'b001_010,
             6'b001_010, 6'b011_000, 6'b011_000, 6'b011_000, 6'b011_000};
    expv = '{pk(2,1,2,0,0), pk(2,1,2,0,0), pk(3,1,3,0,0), pk(3,0,3,0,0),
             pk(3,0,3,0,0), pk(3,0,3,0,0), pk(3,1,3,0,0), pk(4,1,4,0,0),
             pk(4,1,4,0,0), pk(5,1,5,0,0)};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      {rst, en8, mode8, sel8} = stim[i];
      sb.push_back(expv[i]);
      @(posedge clk); #1;
      got = {y8, v8, ch8, wr8, err8};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL freeze[%0d]: got {y,v,ch,wrap,err}=%b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [5:0] stim [7];
    logic [9:0] expv [7];
    logic [9:0] got, exp;
    stim = '{6'b011_001, 6'b011_001, 6'b011_111, 6'b010_111, 6'b011_100,
             6'b011_100, 6'b011_100};
    expv = '{pk(1,1,1,0,0), pk(1,1,1,0,0), pk(2,1,2,0,0), pk(7,1,7,0,0),
             pk(4,1,4,0,0), pk(4,1,4,0,0), pk(5,1,5,0,0)};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      {rst, en8, mode8, sel8} = stim[i];
      sb.push_back(expv[i]);
      @(posedge clk); #1;
      got = {y8, v8, ch8, wr8, err8};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL mode_switch[%0d]: got {y,v,ch,wrap,err}=%b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_nonpow2();
    logic [5:0] stim [11];
    logic [9:0] expv [11];
    logic [9:0] got, exp;
    stim = '{6'b010_010, 6'b010_110, 6'b010_100, 6'b011_110, 6'b011_110,
             6'b011_110, 6'b011_110, 6'b011_110, 6'b011_110, 6'b011_110,
             6'b010_101};
    expv = '{pk(2,1,2,0,0), pk(0,0,2,0,1), pk(4,1,4,0,0), pk(0,1,0,0,0),
             pk(1,1,1,0,0), pk(2,1,2,0,0), pk(3,1,3,0,0), pk(4,1,4,0,0),
             pk(0,1,0,1,0), pk(1,1,1,0,0), pk(0,0,1,0,1)};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      {rst, en5, mode5, sel5} = stim[i];
      sb.push_back(expv[i]);
      @(posedge clk); #1;
      got = {y5, v5, ch5, wr5, err5};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL nonpow2[%0d]: got {y,v,ch,wrap,err}=%b required %b", i, got, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in8 = 32'h7654_3210; sel8 = 3'd0; mode8 = 1'b0; en8 = 1'b0;
    in5 = 20'h4_3210;    sel5 = 3'd0; mode5 = 1'b0; en5 = 1'b0;
    $display("[TB] starting mux_scan_nx1 bench");
    test_reset();
    test_direct();
    test_scan();
    test_scan_full();
    test_freeze();
    test_mode_switch();
    test_nonpow2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
